// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave): hazard sources in, stage enables/bubbles out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_is_mult;
  logic             mem_redirect;

  logic             en_pc;
  logic             en_if_id;
  logic             en_id_ex;
  logic             en_ex_mem;
  logic             en_mem_wb;
  logic             bub_if_id;
  logic             bub_id_ex;
  logic             bub_ex_mem;
  logic             mult_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_memread, ex_rd, ex_is_mult, mem_redirect,
    input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           bub_if_id, bub_id_ex, bub_ex_mem, mult_busy, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_memread, ex_rd, ex_is_mult, mem_redirect,
    output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           bub_if_id, bub_id_ex, bub_ex_mem, mult_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: branch redirect flush, multi-cycle
// multiply stall and load-use stall, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave pipe
);

  typedef enum logic {RUN, MUL} state_e;

  localparam bit         MULT_EN  = (MULT_LAT >= 2);
  localparam logic [3:0] MUL_INIT = MULT_EN ? 4'(MULT_LAT - 2) : 4'd0;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = pipe.ex_memread && (pipe.ex_rd != 5'd0) &&
                    ((pipe.id_use_rs1 && (pipe.id_rs1 == pipe.ex_rd)) ||
                     (pipe.id_use_rs2 && (pipe.id_rs2 == pipe.ex_rd)));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pipe.en_pc      = 1'b1;
    pipe.en_if_id   = 1'b1;
    pipe.en_id_ex   = 1'b1;
    pipe.en_ex_mem  = 1'b1;
    pipe.en_mem_wb  = 1'b1;
    pipe.bub_if_id  = 1'b0;
    pipe.bub_id_ex  = 1'b0;
    pipe.bub_ex_mem = 1'b0;
    pipe.mult_busy  = 1'b0;

    if (rst) begin
      pipe.en_pc     = 1'b0;
      pipe.en_if_id  = 1'b0;
      pipe.en_id_ex  = 1'b0;
      pipe.en_ex_mem = 1'b0;
      pipe.en_mem_wb = 1'b0;
    end else if (pipe.mem_redirect) begin
      // Flush overrides everything, including an in-flight multiply.
      pipe.bub_if_id  = 1'b1;
      pipe.bub_id_ex  = 1'b1;
      pipe.bub_ex_mem = 1'b1;
      state_d         = RUN;
      cnt_d           = '0;
    end else if ((state_q == MUL && cnt_q != 4'd0) ||
                 (state_q == RUN && MULT_EN && pipe.ex_is_mult)) begin
      pipe.en_pc      = 1'b0;
      pipe.en_if_id   = 1'b0;
      pipe.en_id_ex   = 1'b0;
      pipe.bub_ex_mem = 1'b1;
      pipe.mult_busy  = 1'b1;
      state_d         = MUL;
      cnt_d           = (state_q == RUN) ? MUL_INIT : cnt_q - 4'd1;
    end else if (state_q == MUL) begin
      state_d = RUN;
    end else if (load_use) begin
      pipe.en_pc     = 1'b0;
      pipe.en_if_id  = 1'b0;
      pipe.bub_id_ex = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pipe.en_pc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pipe.stall_cnt = stall_cnt_q;

endmodule
